// File: rtl/transaction_commit_if.sv
// Handshake and write-back bundle between the transfer requester, the key
// verifier and the balance store for transaction_commit.
interface transaction_commit_if;
  logic       start;
  logic [2:0] sender_id;
  logic [2:0] receiver_id;
  logic [7:0] sender_balance;
  logic [7:0] receiver_balance;
  logic [7:0] amount;
  logic       key_valid;
  logic       key_correct;
  logic       busy;
  logic       write_en;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic       done;
  logic [1:0] status;

  modport master (
    output start, sender_id, receiver_id, sender_balance, receiver_balance,
           amount, key_valid, key_correct,
    input  busy, write_en, write_addr, write_data, done, status
  );

  modport slave (
    input  start, sender_id, receiver_id, sender_balance, receiver_balance,
           amount, key_valid, key_correct,
    output busy, write_en, write_addr, write_data, done, status
  );
endinterface

// File: rtl/transaction_commit.sv
// Wallet-to-wallet transfer sequencer: waits for key verification, validates
// the transfer, then writes the debited and credited balances back in order.
module transaction_commit #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic                  clock,
  input logic                  reset,
  transaction_commit_if.slave  bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_KEY, CHECK, DEBIT, CREDIT, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    sid_q, sid_d, rid_q, rid_d;
  logic [7:0]    sbal_q, sbal_d, rbal_q, rbal_d, amt_q, amt_d;
  logic          key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    status_q, status_d;
  logic [8:0]    credit_sum;
  logic [CW-1:0] cnt_inc;

  assign credit_sum = {1'b0, rbal_q} + {1'b0, amt_q};
  assign cnt_inc    = cnt_q + CW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sid_q    <= '0;
      rid_q    <= '0;
      sbal_q   <= '0;
      rbal_q   <= '0;
      amt_q    <= '0;
      key_q    <= 1'b0;
      cnt_q    <= '0;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      sid_q    <= sid_d;
      rid_q    <= rid_d;
      sbal_q   <= sbal_d;
      rbal_q   <= rbal_d;
      amt_q    <= amt_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sid_d    = sid_q;
    rid_d    = rid_q;
    sbal_d   = sbal_q;
    rbal_d   = rbal_q;
    amt_d    = amt_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sid_d    = bus.sender_id;
          rid_d    = bus.receiver_id;
          sbal_d   = bus.sender_balance;
          rbal_d   = bus.receiver_balance;
          amt_d    = bus.amount;
          key_d    = 1'b0;
          cnt_d    = '0;
          status_d = 2'b00;
          state_d  = WAIT_KEY;
        end
      end
      WAIT_KEY: begin
        // A strobe on the final allowed cycle still wins over the timeout.
        if (bus.key_valid) begin
          key_d   = bus.key_correct;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            status_d = 2'b11;
            state_d  = DONE;
          end
        end
      end
      CHECK: begin
        if (!key_q) begin
          status_d = 2'b01;
          state_d  = DONE;
        end else if (amt_q > sbal_q) begin
          status_d = 2'b10;
          state_d  = DONE;
        end else if ((sid_q == rid_q) || (amt_q == '0) || credit_sum[8]) begin
          status_d = 2'b11;
          state_d  = DONE;
        end else begin
          status_d = 2'b00;
          state_d  = DEBIT;
        end
      end
      DEBIT:   state_d = CREDIT;
      CREDIT:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.done       = (state_q == DONE);
    bus.status     = status_q;
    bus.write_en   = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;
    if (state_q == DEBIT) begin
      bus.write_en   = 1'b1;
      bus.write_addr = sid_q;
      bus.write_data = sbal_q - amt_q;
    end else if (state_q == CREDIT) begin
      bus.write_en   = 1'b1;
      bus.write_addr = rid_q;
      bus.write_data = credit_sum[7:0];
    end
  end
endmodule

// File: tb/tb_transaction_commit.sv
// Directed bench for transaction_commit: success, each failure status,
// timeout, reset interactions and start-while-busy.
module tb_transaction_commit;
  localparam int unsigned TO = 15;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   n;

  transaction_commit_if bus ();

  transaction_commit #(.TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compares the full output vector {busy, write_en, write_addr, write_data, done, status}.
  task automatic expect_out(input string tag, input logic b, input logic w,
                            input logic [2:0] a, input logic [7:0] d,
                            input logic dn, input logic [1:0] st);
    logic [15:0] obs, exp;
    obs = {bus.busy, bus.write_en, bus.write_addr, bus.write_data, bus.done, bus.status};
    exp = {b, w, a, d, dn, st};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (busy,we,addr,data,done,status)", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input logic [2:0] sid, input logic [2:0] rid,
                           input logic [7:0] sb, input logic [7:0] rb,
                           input logic [7:0] amt);
    bus.sender_id        = sid;
    bus.receiver_id      = rid;
    bus.sender_balance   = sb;
    bus.receiver_balance = rb;
    bus.amount           = amt;
    bus.start            = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Present the key strobe on the n-th WAIT_KEY cycle; returns in CHECK.
  task automatic wait_key(input int n, input logic kc);
    for (int i = 1; i < n; i++) tick();
    bus.key_valid   = 1'b1;
    bus.key_correct = kc;
    tick();
    bus.key_valid   = 1'b0;
    bus.key_correct = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_correct = 1'b0;
    bus.sender_id = '0; bus.receiver_id = '0;
    bus.sender_balance = '0; bus.receiver_balance = '0; bus.amount = '0;
    tick(); tick();
    expect_out("reset_state", 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00);
    reset = 1'b0;
    tick();
    expect_out("idle_after_reset", 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00);

    // Success: key arrives two cycles after start
    start_txn(3'd2, 3'd5, 8'd50, 8'd10, 8'd20);
    expect_out("ok_wait_key", 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00);
    wait_key(2, 1'b1);
    expect_out("ok_check", 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00);
    tick(); expect_out("ok_debit", 1'b1, 1'b1, 3'd2, 8'd30, 1'b0, 2'b00);
    tick(); expect_out("ok_credit", 1'b1, 1'b1, 3'd5, 8'd30, 1'b0, 2'b00);
    tick(); expect_out("ok_done", 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 2'b00);
    tick(); expect_out("ok_idle", 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00);

    // Bad key
    start_txn(3'd2, 3'd5, 8'd50, 8'd10, 8'd20);
    wait_key(1, 1'b0);
    expect_out("badkey_check", 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00);
    tick(); expect_out("badkey_done", 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 2'b01);
    tick(); expect_out("badkey_status_held", 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 2'b01);

    // Insufficient funds, then the exact-balance boundary
    start_txn(3'd1, 3'd4, 8'd15, 8'd40, 8'd16);
    wait_key(1, 1'b1);
    tick(); expect_out("nofunds_done", 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 2'b10);
    tick();
    start_txn(3'd1, 3'd4, 8'd15, 8'd40, 8'd15);
    wait_key(1, 1'b1);
    tick(); expect_out("exact_debit", 1'b1, 1'b1, 3'd1, 8'd0, 1'b0, 2'b00);
    tick(); expect_out("exact_credit", 1'b1, 1'b1, 3'd4, 8'd55, 1'b0, 2'b00);
    tick(); expect_out("exact_done", 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 2'b00);
    tick();

    // Receiver overflow (256) and the largest sum that still fits (255)
    start_txn(3'd3, 3'd6, 8'd100, 8'd250, 8'd6);
    wait_key(1, 1'b1);
    tick(); expect_out("overflow_done", 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 2'b11);
    tick();
    start_txn(3'd3, 3'd6, 8'd100, 8'd249, 8'd6);
    wait_key(1, 1'b1);
    tick(); expect_out("fit_debit", 1'b1, 1'b1, 3'd3, 8'd94, 1'b0, 2'b00);
    tick(); expect_out("fit_credit", 1'b1, 1'b1, 3'd6, 8'd255, 1'b0, 2'b00);
    tick(); tick();

    // Same wallet and zero amount
    start_txn(3'd4, 3'd4, 8'd50, 8'd50, 8'd5);
    wait_key(1, 1'b1);
    tick(); expect_out("same_id_done", 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 2'b11);
    tick();
    start_txn(3'd2, 3'd5, 8'd50, 8'd10, 8'd0);
    wait_key(1, 1'b1);
    tick(); expect_out("zero_amt_done", 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 2'b11);
    tick();

    // Timeout: done lands exactly TO cycles after WAIT_KEY entry
    start_txn(3'd2, 3'd5, 8'd50, 8'd10, 8'd20);
    n = 0;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    checks++;
    assert (n == int'(TO)) else begin
      failures++;
      $error("FAIL timeout_latency observed=%0d expected=%0d", n, TO);
    end
    expect_out("timeout_done", 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 2'b11);
    tick();

    // Key strobe on the last allowed WAIT_KEY cycle is still honoured
    start_txn(3'd2, 3'd5, 8'd50, 8'd10, 8'd20);
    wait_key(int'(TO), 1'b1);
    tick(); expect_out("late_key_debit", 1'b1, 1'b1, 3'd2, 8'd30, 1'b0, 2'b00);
    tick(); tick(); tick();

    // Reset during DEBIT cancels the CREDIT write
    start_txn(3'd2, 3'd5, 8'd50, 8'd10, 8'd20);
    wait_key(1, 1'b1);
    tick(); expect_out("rst_pre_debit", 1'b1, 1'b1, 3'd2, 8'd30, 1'b0, 2'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_out("rst_in_debit", 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00);
    tick(); expect_out("rst_no_credit", 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00);

    // Reset wins over a simultaneous start
    bus.start = 1'b1;
    reset     = 1'b1;
    tick();
    bus.start = 1'b0;
    reset     = 1'b0;
    expect_out("rst_over_start", 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00);

    // Start while busy must not disturb captured operands
    start_txn(3'd2, 3'd5, 8'd50, 8'd10, 8'd20);
    start_txn(3'd1, 3'd3, 8'd100, 8'd100, 8'd7);
    wait_key(1, 1'b1);
    tick(); expect_out("busy_start_debit", 1'b1, 1'b1, 3'd2, 8'd30, 1'b0, 2'b00);
    tick(); expect_out("busy_start_credit", 1'b1, 1'b1, 3'd5, 8'd30, 1'b0, 2'b00);
    tick(); expect_out("busy_start_done", 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 2'b00);
    tick(); expect_out("busy_start_idle", 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
